cluster_unpacker768: RTL and testbench
======================================

CLUSTER_UNPACKER768 -- requirements
Module: cluster_unpacker768

Interface
REQ-001 Parameter MXPADS, default 768: number of pads in the reconstructed hit mask.
REQ-002 Parameter MXCLUSTERS, default 8: maximum clusters accepted per frame.
REQ-003 clock  input  1  sole clock; all logic rising-edge.
REQ-004 global_reset  input  1  synchronous, active-high reset.
REQ-005 latch_in  input  1  frame-boundary strobe; a cluster presented in the same cycle belongs to the new frame.
REQ-006 cluster_valid  input  1  qualifies cluster_adr/cluster_cnt this cycle.
REQ-007 cluster_adr  input  11  first pad of cluster; values >= MXPADS are invalid.
REQ-008 cluster_cnt  input  3  cluster size minus one (0..7 -> 1..8 pads).
REQ-009 vpfs_out  output  MXPADS  reconstructed hit mask of the last completed frame.
REQ-010 cnts_out  output  MXPADS*3  per-pad cnt; pad p slice [p*3+2:p*3] holds cluster_cnt of a cluster starting at p, else 0.
REQ-011 frame_valid  output  1  one-cycle pulse when vpfs_out/cnts_out update.
REQ-012 nclusters  output  4  clusters accepted into the last completed frame (0..MXCLUSTERS).
REQ-013 overflow  output  1  last completed frame received more than MXCLUSTERS valid clusters.
REQ-014 bad_adr  output  1  last completed frame received at least one cluster with cluster_adr >= MXPADS.

Function
REQ-015 Input stage: latch_in, cluster_valid, cluster_adr, cluster_cnt registered together (stage 1), keeping frame alignment.
REQ-016 Stage 2: registered cluster expanded to a mask setting pads adr..adr+cnt, clipped at MXPADS-1 (no wrap-around), and ORed into an accumulation buffer.
REQ-017 cnts buffer: write cnt at pad adr only if that slice is still 0 (first cluster at a pad wins).
REQ-018 State machine: IDLE (after reset; valid clusters discarded, not counted) -> ACCUM on registered latch; ACCUM stays ACCUM.
REQ-019 In ACCUM, registered latch copies buffers and counters to outputs, pulses frame_valid, and clears buffers; the same-cycle registered cluster goes into the cleared buffer.
REQ-020 Latency: latch_in at cycle M -> frame_valid high in cycle M+2; cluster at cycle N < M appears in outputs from M+2.
REQ-021 The first latch after IDLE produces no frame_valid (no frame was open).
REQ-022 Outputs hold between frame_valid pulses.
REQ-023 Per-frame counter saturates at MXCLUSTERS; further valid clusters dropped (not ORed) and set frame overflow flag.
REQ-024 Invalid-address clusters are dropped, not counted, and set frame bad_adr flag; they do not count toward overflow.
REQ-025 Overlapping clusters OR in vpfs_out.
REQ-026 latch_in on consecutive cycles: each closes a frame; empty frames output all-zero with nclusters=0.

Reset
REQ-027 global_reset clears state to IDLE, all buffers, pipeline registers, counters and flags; all outputs read 0 the cycle after reset is sampled.
REQ-028 Reset mid-frame discards the frame; no frame_valid until two latches after reset release.

Structure
REQ-029 Shared package/include holds MXPADS, MXCLUSTERS, address width 11, count width 3, and the size encoding (cnt+1 pads).
REQ-030 One sub-module, cluster_expand: combinational adr/cnt -> MXPADS mask with clipping and valid-address flag.

Verification
REQ-031 Latch, cluster adr=5 cnt=2, latch -> frame_valid 2 cycles after second latch; vpfs_out bits 5..7 set; cnts_out pad 5 = 2; nclusters=1.
REQ-032 Cluster adr=765 cnt=7 -> only bits 765..767 set, no wrap to bit 0.
REQ-033 10 valid clusters in one frame -> first 8 in mask, nclusters=8, overflow=1; next frame with 1 cluster -> overflow=0.
REQ-034 Cluster adr=800 plus adr=0 cnt=0 -> bit 0 only, bad_adr=1, nclusters=1.
REQ-035 Cluster presented with latch_in -> appears in following frame, not the closing one.
REQ-036 global_reset mid-frame after 3 clusters -> outputs 0, next latch gives no frame_valid, subsequent frame contains only post-reset clusters.

Source files
------------

// File: rtl/cluster_unpacker768_pkg.sv
// Shared sizes and helpers for the cluster unpacker: pad count, field widths,
// FSM states and the cluster size encoding (cnt field holds size minus one).
package cluster_unpacker768_pkg;
  localparam int MXPADS_DEF     = 768;
  localparam int MXCLUSTERS_DEF = 8;
  localparam int ADR_W          = 11;
  localparam int CNT_W          = 3;
  localparam int NCL_W          = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic logic [CNT_W:0] pad_count(input logic [CNT_W-1:0] cnt);
    return {1'b0, cnt} + (CNT_W+1)'(1);
  endfunction
endpackage

// File: rtl/cluster_unpacker768_if.sv
// Cluster input bus and reconstructed-frame output bus of the unpacker.
interface cluster_unpacker768_if
  import cluster_unpacker768_pkg::*;
#(
  parameter int MXPADS = MXPADS_DEF
);
  logic                  latch_in;
  logic                  cluster_valid;
  logic [ADR_W-1:0]      cluster_adr;
  logic [CNT_W-1:0]      cluster_cnt;
  logic [MXPADS-1:0]     vpfs_out;
  logic [MXPADS*3-1:0]   cnts_out;
  logic                  frame_valid;
  logic [NCL_W-1:0]      nclusters;
  logic                  overflow;
  logic                  bad_adr;

  modport master (
    output latch_in, cluster_valid, cluster_adr, cluster_cnt,
    input  vpfs_out, cnts_out, frame_valid, nclusters, overflow, bad_adr
  );

  modport slave (
    input  latch_in, cluster_valid, cluster_adr, cluster_cnt,
    output vpfs_out, cnts_out, frame_valid, nclusters, overflow, bad_adr
  );
endinterface

// File: rtl/cluster_unpacker768_expand.sv
// Combinational cluster expansion: pads adr..adr+cnt set, clipped at the last
// pad (never wrapping), plus a flag telling whether the start address exists.
module cluster_expand
  import cluster_unpacker768_pkg::*;
#(
  parameter int MXPADS = MXPADS_DEF
) (
  input  logic [ADR_W-1:0]  adr,
  input  logic [CNT_W-1:0]  cnt,
  output logic [MXPADS-1:0] mask,
  output logic              adr_ok
);
  localparam int AW1 = ADR_W + 1;

  logic [AW1-1:0] first;
  logic [AW1-1:0] last;

  always_comb begin
    first  = {1'b0, adr};
    last   = first + AW1'(pad_count(cnt)) - AW1'(1);
    adr_ok = int'(adr) < MXPADS;
    mask   = '0;
    // Pads beyond MXPADS-1 simply have no bit, which gives the clipping.
    for (int p = 0; p < MXPADS; p++) begin
      mask[p] = adr_ok && (AW1'(p) >= first) && (AW1'(p) <= last);
    end
  end
endmodule

// File: rtl/cluster_unpacker768.sv
// Rebuilds a per-frame pad hit mask and per-pad cluster size map from a stream
// of (adr, cnt) clusters delimited by latch_in strobes.
module cluster_unpacker768
  import cluster_unpacker768_pkg::*;
#(
  parameter int MXPADS     = MXPADS_DEF,
  parameter int MXCLUSTERS = MXCLUSTERS_DEF
) (
  input logic                  clock,
  input logic                  global_reset,
  cluster_unpacker768_if.slave bus
);
  state_t state_q, state_d;

  logic              latch_p1;
  logic              vld_p1;
  logic [ADR_W-1:0]  adr_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic [MXPADS-1:0] mask_p1;
  logic              adr_ok_p1;

  logic [MXPADS-1:0]       vpfs_buf, vpfs_d;
  logic [MXPADS*CNT_W-1:0] cnts_buf, cnts_d;
  logic [NCL_W-1:0]        count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    bad_q, bad_d;
  logic                    close_frame;

  cluster_expand #(.MXPADS(MXPADS)) u_expand (
    .adr    (adr_p1),
    .cnt    (cnt_p1),
    .mask   (mask_p1),
    .adr_ok (adr_ok_p1)
  );

  always_ff @(posedge clock) begin
    if (global_reset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // A registered latch restarts the accumulation; the cluster registered with
  // it is then folded into the freshly cleared buffers, i.e. the new frame.
  always_comb begin
    state_d     = state_q;
    close_frame = 1'b0;
    vpfs_d      = vpfs_buf;
    cnts_d      = cnts_buf;
    count_d     = count_q;
    ovf_d       = ovf_q;
    bad_d       = bad_q;
    if (latch_p1) begin
      state_d     = ACCUM;
      close_frame = (state_q == ACCUM);
      vpfs_d      = '0;
      cnts_d      = '0;
      count_d     = '0;
      ovf_d       = 1'b0;
      bad_d       = 1'b0;
    end
    if ((state_q == ACCUM || latch_p1) && vld_p1) begin
      if (!adr_ok_p1) begin
        bad_d = 1'b1;
      end else if (int'(count_d) >= MXCLUSTERS) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_d + NCL_W'(1);
        vpfs_d  = vpfs_d | mask_p1;
        for (int p = 0; p < MXPADS; p++) begin
          if (adr_p1 == ADR_W'(p) && cnts_d[p*CNT_W +: CNT_W] == '0) begin
            cnts_d[p*CNT_W +: CNT_W] = cnt_p1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (global_reset) begin
      latch_p1        <= 1'b0;
      vld_p1          <= 1'b0;
      adr_p1          <= '0;
      cnt_p1          <= '0;
      vpfs_buf        <= '0;
      cnts_buf        <= '0;
      count_q         <= '0;
      ovf_q           <= 1'b0;
      bad_q           <= 1'b0;
      bus.vpfs_out    <= '0;
      bus.cnts_out    <= '0;
      bus.frame_valid <= 1'b0;
      bus.nclusters   <= '0;
      bus.overflow    <= 1'b0;
      bus.bad_adr     <= 1'b0;
    end else begin
      // stage 1: input capture
      latch_p1 <= bus.latch_in;
      vld_p1   <= bus.cluster_valid;
      adr_p1   <= bus.cluster_adr;
      cnt_p1   <= bus.cluster_cnt;
      // stage 2: accumulation and frame output
      vpfs_buf        <= vpfs_d;
      cnts_buf        <= cnts_d;
      count_q         <= count_d;
      ovf_q           <= ovf_d;
      bad_q           <= bad_d;
      bus.frame_valid <= close_frame;
      if (close_frame) begin
        bus.vpfs_out  <= vpfs_buf;
        bus.cnts_out  <= cnts_buf;
        bus.nclusters <= count_q;
        bus.overflow  <= ovf_q;
        bus.bad_adr   <= bad_q;
      end
    end
  end
endmodule

// File: tb/tb_cluster_unpacker768.sv
// Bench for cluster_unpacker768: directed frame scenarios plus a randomized
// stream checked against a frame-list reference model.
module tb_cluster_unpacker768;
  localparam int NP = 768;
  localparam int NC = 8;

  typedef struct {
    logic [NP-1:0]   vpfs;
    logic [3*NP-1:0] cnts;
    int              n;
    bit              ovf;
    bit              bad;
  } frame_t;

  logic clock        = 1'b0;
  logic global_reset = 1'b0;
  int   vectors      = 0;
  int   miscompares  = 0;

  frame_t exp_q[$];
  frame_t held;
  int     fr_adr[$];
  int     fr_cnt[$];
  bit     fr_open    = 1'b0;
  bit     prev_close = 1'b0;
  bit     exp_fv     = 1'b0;

  always #5 clock = ~clock;

  cluster_unpacker768_if #(.MXPADS(NP)) bus ();

  cluster_unpacker768 #(.MXPADS(NP), .MXCLUSTERS(NC)) dut (
    .clock        (clock),
    .global_reset (global_reset),
    .bus          (bus)
  );

  // Frame contents from the ordered cluster list of one frame.
  function automatic frame_t build_frame();
    frame_t f;
    f.vpfs = '0; f.cnts = '0; f.n = 0; f.ovf = 1'b0; f.bad = 1'b0;
    foreach (fr_adr[i]) begin
      if (fr_adr[i] >= NP) begin
        f.bad = 1'b1;
      end else if (f.n == NC) begin
        f.ovf = 1'b1;
      end else begin
        f.n++;
        for (int k = 0; k <= fr_cnt[i]; k++)
          if (fr_adr[i] + k < NP) f.vpfs[fr_adr[i] + k] = 1'b1;
        if (f.cnts[fr_adr[i]*3 +: 3] == 3'd0) f.cnts[fr_adr[i]*3 +: 3] = 3'(fr_cnt[i]);
      end
    end
    return f;
  endfunction

  task automatic cyc(input bit l, input bit v, input int a, input int c);
    bit closing;
    closing = l && fr_open;
    if (closing) begin
      exp_q.push_back(build_frame());
      fr_adr.delete();
      fr_cnt.delete();
    end
    if (l) fr_open = 1'b1;
    if (v && fr_open) begin
      fr_adr.push_back(a);
      fr_cnt.push_back(c);
    end
    bus.latch_in      = l;
    bus.cluster_valid = v;
    bus.cluster_adr   = 11'(a);
    bus.cluster_cnt   = 3'(c);
    @(posedge clock);
    #1;
    exp_fv     = prev_close;
    prev_close = closing;
    bus.latch_in      = 1'b0;
    bus.cluster_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.latch_in = 1'b0; bus.cluster_valid = 1'b0;
    bus.cluster_adr = '0; bus.cluster_cnt = '0;
    global_reset = 1'b1;
    @(posedge clock);
    #1;
    global_reset = 1'b0;
    fr_open = 1'b0; prev_close = 1'b0; exp_fv = 1'b0;
    fr_adr.delete(); fr_cnt.delete(); exp_q.delete();
    held.vpfs = '0; held.cnts = '0; held.n = 0; held.ovf = 1'b0; held.bad = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fv: got %b want 0", bus.frame_valid); end
    vectors++; if (bus.vpfs_out !== '0) begin miscompares++; $display("FAIL reset_vpfs: got %h want 0", bus.vpfs_out); end
    vectors++; if (bus.cnts_out !== '0) begin miscompares++; $display("FAIL reset_cnts: nonzero, want 0"); end
    vectors++; if ({bus.nclusters, bus.overflow, bus.bad_adr} !== 6'd0) begin
      miscompares++; $display("FAIL reset_flags: got n=%0d ovf=%b bad=%b want 0", bus.nclusters, bus.overflow, bus.bad_adr); end
  endtask

  task automatic test_basic();
    logic [NP-1:0] m;
    m = '0; m[7:5] = 3'b111;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 5, 2);
    vectors++; if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL first_latch_fv: got %b want 0", bus.frame_valid); end
    cyc(1, 0, 0, 0);
    vectors++; if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL basic_fv_early: got %b want 0", bus.frame_valid); end
    cyc(0, 0, 0, 0);
    vectors++; if (bus.frame_valid !== 1'b1) begin miscompares++; $display("FAIL basic_fv: got %b want 1", bus.frame_valid); end
    vectors++; if (bus.vpfs_out !== m) begin miscompares++; $display("FAIL basic_vpfs: got %h want %h", bus.vpfs_out, m); end
    vectors++; if (bus.cnts_out !== (3*NP)'(2) << 15) begin miscompares++; $display("FAIL basic_cnts: pad5 got %0d want 2", bus.cnts_out[17:15]); end
    vectors++; if (bus.nclusters !== 4'd1) begin miscompares++; $display("FAIL basic_n: got %0d want 1", bus.nclusters); end
    cyc(0, 0, 0, 0);
    vectors++; if (bus.frame_valid !== 1'b0 || bus.vpfs_out !== m) begin
      miscompares++; $display("FAIL basic_hold: fv=%b vpfs=%h want fv=0 vpfs=%h", bus.frame_valid, bus.vpfs_out, m); end
  endtask

  task automatic test_clip();
    logic [NP-1:0] m;
    m = '0; m[767:765] = 3'b111;
    cyc(0, 1, 765, 7);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    vectors++; if (bus.frame_valid !== 1'b1) begin miscompares++; $display("FAIL clip_fv: got %b want 1", bus.frame_valid); end
    vectors++; if (bus.vpfs_out !== m) begin miscompares++; $display("FAIL clip_vpfs: got %h want %h", bus.vpfs_out, m); end
    vectors++; if (bus.cnts_out[765*3 +: 3] !== 3'd7) begin miscompares++; $display("FAIL clip_cnts: got %0d want 7", bus.cnts_out[765*3 +: 3]); end
  endtask

  task automatic test_overflow();
    logic [NP-1:0] m;
    m = '0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, i*10, 0);
      if (i < 8) m[i*10] = 1'b1;
    end
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    vectors++; if (bus.vpfs_out !== m) begin miscompares++; $display("FAIL ovf_vpfs: got %h want %h", bus.vpfs_out, m); end
    vectors++; if (bus.nclusters !== 4'd8 || bus.overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_flags: got n=%0d ovf=%b want n=8 ovf=1", bus.nclusters, bus.overflow); end
    m = '0; m[401:400] = 2'b11;
    cyc(0, 1, 400, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    vectors++; if (bus.vpfs_out !== m || bus.nclusters !== 4'd1 || bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL ovf_next: got n=%0d ovf=%b want n=1 ovf=0", bus.nclusters, bus.overflow); end
  endtask

  task automatic test_bad_adr();
    logic [NP-1:0] m;
    m = '0; m[0] = 1'b1;
    cyc(0, 1, 800, 3);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    vectors++; if (bus.vpfs_out !== m) begin miscompares++; $display("FAIL bad_vpfs: got %h want %h", bus.vpfs_out, m); end
    vectors++; if (bus.bad_adr !== 1'b1 || bus.nclusters !== 4'd1 || bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL bad_flags: got bad=%b n=%0d ovf=%b want bad=1 n=1 ovf=0", bus.bad_adr, bus.nclusters, bus.overflow); end
  endtask

  task automatic test_back_to_back();
    logic [NP-1:0] m;
    m = '0; m[300] = 1'b1;
    cyc(0, 1, 300, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    vectors++; if (bus.frame_valid !== 1'b1 || bus.vpfs_out !== m) begin
      miscompares++; $display("FAIL b2b_first: fv=%b vpfs=%h want fv=1 vpfs=%h", bus.frame_valid, bus.vpfs_out, m); end
    cyc(1, 0, 0, 0);
    vectors++; if (bus.frame_valid !== 1'b1 || bus.vpfs_out !== '0 || bus.nclusters !== 4'd0) begin
      miscompares++; $display("FAIL b2b_empty: fv=%b n=%0d want fv=1 n=0 vpfs=0", bus.frame_valid, bus.nclusters); end
    cyc(0, 0, 0, 0);
    vectors++; if (bus.frame_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_third: got %b want 1", bus.frame_valid); end
    cyc(0, 0, 0, 0);
    vectors++; if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got %b want 0", bus.frame_valid); end
  endtask

  task automatic test_latch_align();
    logic [NP-1:0] m;
    m = '0; m[101:100] = 2'b11;
    cyc(0, 1, 100, 1);
    cyc(1, 1, 200, 0);
    cyc(0, 0, 0, 0);
    vectors++; if (bus.vpfs_out !== m) begin miscompares++; $display("FAIL align_closing: got %h want %h", bus.vpfs_out, m); end
    m = '0; m[200] = 1'b1;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    vectors++; if (bus.frame_valid !== 1'b1 || bus.vpfs_out !== m || bus.nclusters !== 4'd1) begin
      miscompares++; $display("FAIL align_next: fv=%b n=%0d vpfs=%h want fv=1 n=1 vpfs=%h", bus.frame_valid, bus.nclusters, bus.vpfs_out, m); end
  endtask

  task automatic test_reset_midframe();
    logic [NP-1:0] m;
    cyc(0, 1, 10, 0);
    cyc(0, 1, 20, 0);
    cyc(0, 1, 30, 0);
    do_reset();
    vectors++; if (bus.vpfs_out !== '0 || bus.nclusters !== 4'd0 || bus.frame_valid !== 1'b0) begin
      miscompares++; $display("FAIL midrst_out: fv=%b n=%0d vpfs=%h want all 0", bus.frame_valid, bus.nclusters, bus.vpfs_out); end
    cyc(0, 1, 40, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    vectors++; if (bus.frame_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_first_latch: got %b want 0", bus.frame_valid); end
    m = '0; m[50] = 1'b1;
    cyc(0, 1, 50, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    vectors++; if (bus.frame_valid !== 1'b1 || bus.vpfs_out !== m || bus.nclusters !== 4'd1) begin
      miscompares++; $display("FAIL midrst_frame: fv=%b n=%0d vpfs=%h want fv=1 n=1 vpfs=%h", bus.frame_valid, bus.nclusters, bus.vpfs_out, m); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      bit l, v;
      int a, c, pad;
      l = ($urandom_range(0, 9) == 0);
      v = ($urandom_range(0, 2) != 0);
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(755, 830)) : int'($urandom_range(0, 40));
      c = int'($urandom_range(0, 7));
      cyc(l, v, a, c);
      vectors++;
      if (bus.frame_valid !== exp_fv) begin
        miscompares++; $display("FAIL rand_fv: cycle %0d got %b want %b", i, bus.frame_valid, exp_fv);
      end
      if (exp_fv) begin
        if (exp_q.size() > 0) held = exp_q.pop_front();
      end
      vectors++;
      if (bus.vpfs_out !== held.vpfs) begin
        miscompares++; $display("FAIL rand_vpfs: cycle %0d got %h want %h", i, bus.vpfs_out, held.vpfs);
      end
      vectors++;
      if (bus.cnts_out !== held.cnts) begin
        pad = 0;
        for (int p = NP - 1; p >= 0; p--) if (bus.cnts_out[p*3 +: 3] !== held.cnts[p*3 +: 3]) pad = p;
        miscompares++; $display("FAIL rand_cnts: cycle %0d pad %0d got %0d want %0d", i, pad, bus.cnts_out[pad*3 +: 3], held.cnts[pad*3 +: 3]);
      end
      vectors++;
      if (bus.nclusters !== 4'(held.n) || bus.overflow !== held.ovf || bus.bad_adr !== held.bad) begin
        miscompares++; $display("FAIL rand_flags: cycle %0d got n=%0d ovf=%b bad=%b want n=%0d ovf=%b bad=%b",
                                i, bus.nclusters, bus.overflow, bus.bad_adr, held.n, held.ovf, held.bad);
      end
    end
  endtask

  initial begin
    bus.latch_in = 1'b0; bus.cluster_valid = 1'b0;
    bus.cluster_adr = '0; bus.cluster_cnt = '0;
    test_reset();
    test_basic();
    test_clip();
    test_overflow();
    test_bad_adr();
    test_back_to_back();
    test_latch_align();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
